// File: rtl/ddr_stream_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_stream_receiver
//  Purpose  : Single-lane DDR I/Q stream receiver. Captures two bits per clk,
//             finds 32-bit frames on the I/Q sync bits (01 / 10) at either bit
//             phase, and delivers 14-bit I and Q samples with lock and error
//             status.
//  Options  : RX_PN_SWAP_EN - invert captured bits (P/N pair swapped on board)
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_stream_receiver #(
    parameter int LOCK_FRAMES = 4,
    parameter int ERR_LIMIT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ddr_data_in,
    output logic [13:0] i_data,
    output logic [13:0] q_data,
    output logic        sample_valid,
    output logic        locked,
    output logic        sync_err,
    output logic        phase,
    output logic [15:0] err_count
);

    localparam int c_good_w = $clog2(LOCK_FRAMES + 1);
    localparam int c_bad_w  = $clog2(ERR_LIMIT + 1);
    localparam logic [c_good_w-1:0] c_lock_target = c_good_w'(LOCK_FRAMES);
    localparam logic [c_bad_w-1:0]  c_err_target  = c_bad_w'(ERR_LIMIT);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_neg_bit;
    logic                r_q0;
    logic                r_q1;
    logic [1:0]          r_dibit;
    logic [1:0]          w_dibit;
    // The oldest bit of the 34-bit history never falls inside either frame
    // window, so only bits [32:0] are kept.
    logic [32:0]         r_sr;
    logic [3:0]          r_fcnt;
    logic [c_good_w-1:0] r_good_cnt;
    logic [c_bad_w-1:0]  r_bad_cnt;
    logic                r_phase;
    logic [13:0]         r_i_data;
    logic [13:0]         r_q_data;
    logic                r_valid;
    logic                r_sync_err;
    logic [15:0]         r_err_count;

    logic                w_good0;
    logic                w_good1;
    logic                w_use_phase;
    logic [31:0]         w_win;
    logic                w_win_good;
    logic                w_check;
    logic                w_take;
    logic                w_take_phase;
    logic                w_emit;
    logic                w_bad;

    // DDR capture, IDDRX1F behaviour: falling edge holds the first (older) bit.
    always_ff @(negedge clk) begin
        r_neg_bit <= ddr_data_in;
    end

    // Rising edge presents Q0 (older bit) and Q1 together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q0 <= 1'b0;
            r_q1 <= 1'b0;
        end else begin
            r_q0 <= r_neg_bit;
            r_q1 <= ddr_data_in;
        end
    end

`ifdef RX_PN_SWAP_EN
    assign w_dibit = ~{r_q0, r_q1};
`else
    assign w_dibit = {r_q0, r_q1};
`endif

    // Register the dibit, then shift it into the bit history, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dibit <= 2'b00;
            r_sr    <= '0;
        end else begin
            r_dibit <= w_dibit;
            r_sr    <= {r_sr[30:0], r_dibit};
        end
    end

    assign w_good0     = (r_sr[31:30] == 2'b01) && (r_sr[15:14] == 2'b10);
    assign w_good1     = (r_sr[32:31] == 2'b01) && (r_sr[16:15] == 2'b10);
    // While hunting, the window follows the candidate (phase 0 wins ties);
    // otherwise it follows the latched phase.
    assign w_use_phase = (r_state == S_HUNT) ? ~w_good0 : r_phase;
    assign w_win       = w_use_phase ? r_sr[32:1] : r_sr[31:0];
    assign w_win_good  = (w_win[31:30] == 2'b01) && (w_win[15:14] == 2'b10);
    assign w_check     = (r_state != S_HUNT) && (r_fcnt == 4'd0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the per-cycle take / emit / error decisions.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_take_phase = 1'b0;
        w_emit       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_good0 || w_good1) begin
                    w_take       = 1'b1;
                    w_take_phase = ~w_good0;
                    if (LOCK_FRAMES == 1) begin
                        w_state_next = S_LOCKED;
                        w_emit       = 1'b1;
                    end else begin
                        w_state_next = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                if (w_check) begin
                    if (w_win_good) begin
                        if ((r_good_cnt + c_good_w'(1)) == c_lock_target) begin
                            w_state_next = S_LOCKED;
                            w_emit       = 1'b1;
                        end
                    end else begin
                        w_bad        = 1'b1;
                        w_state_next = S_HUNT;
                    end
                end
            end
            S_LOCKED: begin
                if (w_check) begin
                    if (w_win_good) begin
                        w_emit = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                        if ((r_bad_cnt + c_bad_w'(1)) == c_err_target) begin
                            w_state_next = S_HUNT;
                        end
                    end
                end
            end
            default: w_state_next = S_HUNT;
        endcase
    end

    // Frame counters, latched phase, sample outputs and error accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt      <= 4'd0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_phase     <= 1'b0;
            r_i_data    <= 14'd0;
            r_q_data    <= 14'd0;
            r_valid     <= 1'b0;
            r_sync_err  <= 1'b0;
            r_err_count <= 16'd0;
        end else begin
            r_valid    <= w_emit;
            r_sync_err <= w_bad;
            if (w_emit) begin
                r_i_data <= w_win[29:16];
                r_q_data <= w_win[13:0];
            end
            if (w_bad && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (w_take) begin
                r_phase    <= w_take_phase;
                r_fcnt     <= 4'd15;
                r_good_cnt <= c_good_w'(1);
                r_bad_cnt  <= '0;
            end else if (r_state != S_HUNT) begin
                r_fcnt <= r_fcnt - 4'd1;
                if (w_check) begin
                    if (w_win_good) begin
                        r_bad_cnt <= '0;
                        if (r_state == S_VERIFY) begin
                            r_good_cnt <= r_good_cnt + c_good_w'(1);
                        end
                    end else if (r_state == S_LOCKED) begin
                        r_bad_cnt <= r_bad_cnt + c_bad_w'(1);
                    end
                end
            end
        end
    end

    assign i_data       = r_i_data;
    assign q_data       = r_q_data;
    assign sample_valid = r_valid;
    assign locked       = (r_state == S_LOCKED);
    assign sync_err     = r_sync_err;
    assign phase        = r_phase;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ddr_stream_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_stream_receiver
//  Purpose  : Directed self-checking bench for ddr_stream_receiver: phase-0
//             acquisition, sample data, tolerated and fatal sync errors,
//             relock, reset while locked, and phase-1 acquisition.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_stream_receiver;

`ifdef RX_PN_SWAP_EN
    localparam bit c_SWAP = 1'b1;
`else
    localparam bit c_SWAP = 1'b0;
`endif
    localparam logic [31:0] c_GOOD = 32'h7FFF_BFFF;
    localparam logic [31:0] c_BAD  = 32'h3FFF_7FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ddr_data_in;
    logic [13:0] i_data;
    logic [13:0] q_data;
    logic        sample_valid;
    logic        locked;
    logic        sync_err;
    logic        phase;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int n;
    bit bitq[$];

    ddr_stream_receiver dut (
        .clk          (clk),
        .rst          (rst),
        .ddr_data_in  (ddr_data_in),
        .i_data       (i_data),
        .q_data       (q_data),
        .sample_valid (sample_valid),
        .locked       (locked),
        .sync_err     (sync_err),
        .phase        (phase),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) bitq.push_back(w[i]);
    endtask

    // One clk: first bit in the high phase, second in the low phase.
    // Returns just after the falling edge, when outputs are stable.
    task automatic tick();
        bit a;
        bit b;
        a = (bitq.size() > 0) ? bitq.pop_front() : 1'b1;
        b = (bitq.size() > 0) ? bitq.pop_front() : 1'b1;
        @(posedge clk);
        #1 ddr_data_in = a ^ c_SWAP;
        @(negedge clk);
        #1 ddr_data_in = b ^ c_SWAP;
    endtask

    task automatic wait_lock(input int bound, output int cnt);
        cnt = 0;
        while (!locked && cnt < bound) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_i"}, 32'(i_data), 32'h0);
        check({tag, "_q"}, 32'(q_data), 32'h0);
        check({tag, "_valid"}, 32'(sample_valid), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_syncerr"}, 32'(sync_err), 32'h0);
        check({tag, "_phase"}, 32'(phase), 32'h0);
        check({tag, "_errcnt"}, 32'(err_count), 32'h0);
    endtask

    // Advance one 16-clk frame period and check the frame-boundary outputs.
    task automatic next_frame(input string tag, input logic [13:0] ei, input logic [13:0] eq,
                              input logic ev, input logic ee, input logic el);
        logic stray;
        stray = 1'b0;
        repeat (15) begin
            tick();
            if (sample_valid || sync_err) stray = 1'b1;
        end
        tick();
        check({tag, "_stray"}, 32'(stray), 32'h0);
        check({tag, "_valid"}, 32'(sample_valid), 32'(ev));
        check({tag, "_syncerr"}, 32'(sync_err), 32'(ee));
        check({tag, "_locked"}, 32'(locked), 32'(el));
        check({tag, "_i"}, 32'(i_data), 32'(ei));
        check({tag, "_q"}, 32'(q_data), 32'(eq));
    endtask

    initial begin
        rst         = 1'b1;
        ddr_data_in = 1'b1 ^ c_SWAP;

        // Reset state
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        repeat (20) tick();
        check("idle_unlocked", 32'(locked), 32'h0);

        // Phase-0 stream: frames 1-6 good, 7-9 data, 10-11 bad, 12-13 good,
        // 14-16 bad, then good frames
        repeat (6) push_word(c_GOOD);
        push_word(32'h4123_8ABC);
        push_word(32'h5FFF_8000);
        push_word(32'h6000_A001);
        repeat (2) push_word(c_BAD);
        repeat (2) push_word(c_GOOD);
        repeat (3) push_word(c_BAD);
        repeat (40) push_word(c_GOOD);

        wait_lock(200, n);
        check("lock_latency", 32'(n), 32'd68);
        check("lock_valid", 32'(sample_valid), 32'h1);
        check("lock_i", 32'(i_data), 32'h3FFF);
        check("lock_q", 32'(q_data), 32'h3FFF);
        check("lock_phase", 32'(phase), 32'h0);
        check("lock_errcnt", 32'(err_count), 32'h0);

        next_frame("f5", 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);
        next_frame("f6", 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);
        next_frame("f7", 14'h0123, 14'h0ABC, 1'b1, 1'b0, 1'b1);
        next_frame("f8", 14'h1FFF, 14'h0000, 1'b1, 1'b0, 1'b1);
        next_frame("f9", 14'h2000, 14'h2001, 1'b1, 1'b0, 1'b1);

        // Two bad frames: tolerated, outputs held
        next_frame("bad1", 14'h2000, 14'h2001, 1'b0, 1'b1, 1'b1);
        next_frame("bad2", 14'h2000, 14'h2001, 1'b0, 1'b1, 1'b1);
        check("errcnt_after2", 32'(err_count), 32'd2);
        next_frame("f12", 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);
        next_frame("f13", 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);

        // Three bad frames: lock lost on the third
        next_frame("bad3", 14'h3FFF, 14'h3FFF, 1'b0, 1'b1, 1'b1);
        next_frame("bad4", 14'h3FFF, 14'h3FFF, 1'b0, 1'b1, 1'b1);
        next_frame("bad5", 14'h3FFF, 14'h3FFF, 1'b0, 1'b1, 1'b0);
        check("errcnt_after5", 32'(err_count), 32'd5);

        wait_lock(100, n);
        check("relock_latency", 32'(n), 32'd64);
        check("relock_valid", 32'(sample_valid), 32'h1);
        check("relock_phase", 32'(phase), 32'h0);
        check("relock_errcnt", 32'(err_count), 32'd5);
        next_frame("f21", 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);

        // One-clk reset while locked
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        wait_lock(200, n);
        check("rst_relock", 32'(locked), 32'h1);
        check("rst_relock_phase", 32'(phase), 32'h0);
        check("rst_relock_i", 32'(i_data), 32'h3FFF);
        next_frame("rst_f", 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);

        // Phase-1 stream: delayed by one bit
        rst = 1'b1;
        bitq.delete();
        repeat (3) tick();
        rst = 1'b0;
        check("ph1_unlocked", 32'(locked), 32'h0);
        repeat (20) tick();
        bitq.push_back(1'b1);
        repeat (10) push_word(c_GOOD);
        wait_lock(150, n);
        check("ph1_latency", 32'(n), 32'd69);
        check("ph1_phase", 32'(phase), 32'h1);
        check("ph1_valid", 32'(sample_valid), 32'h1);
        check("ph1_i", 32'(i_data), 32'h3FFF);
        check("ph1_q", 32'(q_data), 32'h3FFF);
        next_frame("ph1_f5", 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);
        check("ph1_errcnt", 32'(err_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
